param_uflop: RTL and testbench

PARAM_UFLOP -- requirements
Module: param_uflop

---
 rtl/param_uflop.sv | 105 ++++++++++
 tb/tb_param_uflop.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_uflop.sv
// ---------------------------------------------------------------------------
// param_uflop
//   Up/down counter with load, a runtime upper bound, a wrap or saturate mode,
//   a lookahead output and a sticky overflow flag.
//
//   Parameters
//     WIDTH      counter/data width in bits (>= 1)
//     STEP       increment/decrement amount (1 .. 2^WIDTH-1)
//     SATURATE   0 = wrap at the bounds, 1 = hold at the bounds
//     RESET_VAL  value of q while and after reset
//
//   Ports
//     clk     in   rising-edge clock
//     reset   in   asynchronous active-high reset
//     a       in   load value (clipped to max)
//     max     in   runtime upper bound, legal range is 0..max
//     clear   in   synchronous clear, highest priority (also clears ovf)
//     load    in   load request
//     enable  in   count request
//     up      in   count direction, 1 = up, 0 = down
//     out     out  combinational next value of q (zero-cycle lookahead)
//     q       out  registered count
//     tc      out  combinational terminal count: this cycle's count wraps
//                  or saturates
//     ovf     out  sticky flag, set the edge after any tc cycle, cleared
//                  only by clear or reset
// ---------------------------------------------------------------------------
module param_uflop #(
   parameter int WIDTH     = 3,
   parameter int STEP      = 1,
   parameter int SATURATE  = 0,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] max,
   input  logic             clear,
   input  logic             load,
   input  logic             enable,
   input  logic             up,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
   localparam logic             SAT     = (SATURATE != 0);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH:0]   sum;
   logic             tc_c;

   // The up sum carries one extra bit so q + STEP never loses its carry.
   // When q already sits above a lowered max, sum > max holds automatically,
   // so an up count takes the bound branch; a down count with q >= STEP is
   // deliberately left unclipped.
   always_comb begin
      nxt  = q;
      tc_c = 1'b0;
      sum  = {1'b0, q} + STEP_X;
      if (clear) begin
         nxt = '0;
      end else if (load) begin
         nxt = (a <= max) ? a : max;
      end else if (enable) begin
         if (up) begin
            if (sum <= {1'b0, max}) begin
               nxt = sum[WIDTH-1:0];
            end else begin
               tc_c = 1'b1;
               nxt  = SAT ? max : '0;
            end
         end else begin
            if (q >= STEP_W) begin
               nxt = q - STEP_W;
            end else begin
               tc_c = 1'b1;
               nxt  = SAT ? '0 : max;
            end
         end
      end
   end

   assign out = nxt;
   assign tc  = tc_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q   <= RESET_Q;
         ovf <= 1'b0;
      end else begin
         q <= nxt;
         if (clear) begin
            ovf <= 1'b0;
         end else if (tc_c) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_param_uflop.sv
// ---------------------------------------------------------------------------
// tb_param_uflop
//   Three instances sharing one set of inputs:
//     dut_w : defaults (WIDTH 3, STEP 1, wrap, RESET_VAL 0)
//     dut_s : saturate mode, STEP 1
//     dut_3 : STEP 3, wrap, RESET_VAL 2
//   A vector table drives dut_w; hand-written sequences cover saturation,
//   STEP 3 down-wrap, asynchronous reset and max = 0.
// ---------------------------------------------------------------------------
module tb_param_uflop;

   logic       clk;
   logic       reset;
   logic [2:0] a;
   logic [2:0] max;
   logic       clear;
   logic       load;
   logic       enable;
   logic       up;

   logic [2:0] out_w, q_w, out_s, q_s, out_3, q_3;
   logic       tc_w, ovf_w, tc_s, ovf_s, tc_3, ovf_3;

   int total;
   int bad;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   param_uflop dut_w (
      .clk(clk), .reset(reset), .a(a), .max(max), .clear(clear), .load(load),
      .enable(enable), .up(up), .out(out_w), .q(q_w), .tc(tc_w), .ovf(ovf_w)
   );

   param_uflop #(.SATURATE(1)) dut_s (
      .clk(clk), .reset(reset), .a(a), .max(max), .clear(clear), .load(load),
      .enable(enable), .up(up), .out(out_s), .q(q_s), .tc(tc_s), .ovf(ovf_s)
   );

   param_uflop #(.STEP(3), .RESET_VAL(2)) dut_3 (
      .clk(clk), .reset(reset), .a(a), .max(max), .clear(clear), .load(load),
      .enable(enable), .up(up), .out(out_3), .q(q_3), .tc(tc_3), .ovf(ovf_3)
   );

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic c, input logic l, input logic e, input logic u,
                        input logic [2:0] av, input logic [2:0] mv);
      clear  = c;
      load   = l;
      enable = e;
      up     = u;
      a      = av;
      max    = mv;
   endtask

   task automatic pulse_reset();
      drive(0, 0, 0, 0, 3'd0, 3'd7);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic       c, l, e, u;
      logic [2:0] av, mv;
      logic [2:0] e_out;
      logic       e_tc;
      logic [2:0] e_q;
      logic       e_ovf;
   } vec_t;

   vec_t tbl [23];

   logic [2:0] seq_out [4];
   logic       seq_tc  [4];

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 3'd0, 3'd7);

      //                c  l  e  u  a     max   out   tc q     ovf
      tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd1,1'b0,3'd1,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd2,1'b0,3'd2,1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd3,1'b0,3'd3,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd4,1'b0,3'd4,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd5,1'b0,3'd5,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd6,1'b0,3'd6,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd7,1'b0,3'd7,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd0,1'b1,3'd0,1'b1};
      tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd7,3'd1,1'b0,3'd1,1'b1};
      // hold
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,3'd0,3'd7,3'd1,1'b0,3'd1,1'b1};
      // down 1 -> 0, then 0 wraps to max
      tbl[10] = '{1'b0,1'b0,1'b1,1'b0,3'd0,3'd7,3'd0,1'b0,3'd0,1'b1};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b0,3'd0,3'd7,3'd7,1'b1,3'd7,1'b1};
      // loads: in range, then clipped to max
      tbl[12] = '{1'b0,1'b1,1'b0,1'b0,3'd5,3'd7,3'd5,1'b0,3'd5,1'b1};
      tbl[13] = '{1'b0,1'b1,1'b0,1'b0,3'd6,3'd4,3'd4,1'b0,3'd4,1'b1};
      // q above lowered max, up count wraps
      tbl[14] = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd2,3'd0,1'b1,3'd0,1'b1};
      // q above lowered max, down count is unclipped
      tbl[15] = '{1'b0,1'b1,1'b0,1'b0,3'd6,3'd7,3'd6,1'b0,3'd6,1'b1};
      tbl[16] = '{1'b0,1'b0,1'b1,1'b0,3'd0,3'd3,3'd5,1'b0,3'd5,1'b1};
      // clear beats load and enable, clears ovf; then clipped load
      tbl[17] = '{1'b1,1'b1,1'b1,1'b1,3'd5,3'd7,3'd0,1'b0,3'd0,1'b0};
      tbl[18] = '{1'b0,1'b1,1'b0,1'b0,3'd6,3'd4,3'd4,1'b0,3'd4,1'b0};
      // max = 0
      tbl[19] = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd0,3'd0,1'b1,3'd0,1'b1};
      tbl[20] = '{1'b0,1'b0,1'b1,1'b1,3'd0,3'd0,3'd0,1'b1,3'd0,1'b1};
      tbl[21] = '{1'b0,1'b0,1'b1,1'b0,3'd0,3'd0,3'd0,1'b1,3'd0,1'b1};
      tbl[22] = '{1'b1,1'b0,1'b0,1'b0,3'd0,3'd7,3'd0,1'b0,3'd0,1'b0};

      // ---------------- reset state ----------------
      @(negedge clk);
      chk("rst_q_w", q_w, 3'd0);
      chk("rst_ovf_w", ovf_w, 1'b0);
      chk("rst_q_3", q_3, 3'd2);
      chk("rst_ovf_3", ovf_3, 1'b0);
      reset = 1'b0;

      // ---------------- vector table on dut_w ----------------
      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].av, tbl[i].mv);
         #1;
         chk($sformatf("v%0d_out", i), out_w, tbl[i].e_out);
         chk($sformatf("v%0d_tc", i), tc_w, tbl[i].e_tc);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_q", i), q_w, tbl[i].e_q);
         chk($sformatf("v%0d_ovf", i), ovf_w, tbl[i].e_ovf);
         @(negedge clk);
      end

      // ---------------- STEP 3 down wrap from q = RESET_VAL = 2 ----------------
      pulse_reset();
      seq_out[0] = 3'd7; seq_tc[0] = 1'b1;
      seq_out[1] = 3'd4; seq_tc[1] = 1'b0;
      seq_out[2] = 3'd1; seq_tc[2] = 1'b0;
      seq_out[3] = 3'd7; seq_tc[3] = 1'b1;
      chk("s3_start_q", q_3, 3'd2);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0, 3'd0, 3'd7);
         #1;
         chk($sformatf("s3_%0d_out", i), out_3, seq_out[i]);
         chk($sformatf("s3_%0d_tc", i), tc_3, seq_tc[i]);
         @(posedge clk);
         #1;
         chk($sformatf("s3_%0d_q", i), q_3, seq_out[i]);
         chk($sformatf("s3_%0d_ovf", i), ovf_3, 1'b1);
         @(negedge clk);
      end

      // ---------------- saturate at max = 5 from q = 4 ----------------
      pulse_reset();
      drive(0, 1, 0, 0, 3'd4, 3'd5);
      @(posedge clk); #1;
      chk("sat_load_q", q_s, 3'd4);
      @(negedge clk);
      drive(0, 0, 1, 1, 3'd0, 3'd5);
      #1;
      chk("sat0_tc", tc_s, 1'b0);
      @(posedge clk); #1;
      chk("sat0_q", q_s, 3'd5);
      chk("sat0_ovf", ovf_s, 1'b0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk); #1;
         chk($sformatf("sat%0d_out", i), out_s, 3'd5);
         chk($sformatf("sat%0d_tc", i), tc_s, 1'b1);
         @(posedge clk); #1;
         chk($sformatf("sat%0d_q", i), q_s, 3'd5);
         chk($sformatf("sat%0d_ovf", i), ovf_s, 1'b1);
      end
      @(negedge clk);

      // ---------------- asynchronous reset mid-cycle from q = 6 ----------------
      drive(0, 1, 0, 0, 3'd6, 3'd7);
      @(posedge clk); #1;
      chk("ar_pre_q_w", q_w, 3'd6);
      @(negedge clk);
      drive(0, 0, 1, 1, 3'd0, 3'd7);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_q_w", q_w, 3'd0);
      chk("ar_q_3", q_3, 3'd2);
      chk("ar_ovf_s", ovf_s, 1'b0);
      chk("ar_out_w", out_w, 3'd1);
      chk("ar_out_3", out_3, 3'd5);
      chk("ar_tc_w", tc_w, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("ar_hold_q_w", q_w, 3'd0);
      chk("ar_hold_q_3", q_3, 3'd2);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ar_rel_q_w", q_w, 3'd1);
      chk("ar_rel_q_3", q_3, 3'd5);
      @(negedge clk);

      // ---------------- max = 0 in saturate mode ----------------
      drive(1, 0, 0, 0, 3'd0, 3'd0);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, (i < 2), 3'd0, 3'd0);
         #1;
         chk($sformatf("m0s_%0d_out", i), out_s, 3'd0);
         chk($sformatf("m0s_%0d_tc", i), tc_s, 1'b1);
         chk($sformatf("m0w_%0d_tc", i), tc_w, 1'b1);
         @(posedge clk); #1;
         chk($sformatf("m0s_%0d_q", i), q_s, 3'd0);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
